// File: rtl/rice_partition_sequencer.sv
// Sequences one FLAC residual block through the Rice encoder/writer pair:
// per-partition parameter fetch, sample streaming, pipeline drain, final flush.
module rice_partition_sequencer #(
    parameter int ENC_LATENCY = 2,
    parameter int MAX_ORDER   = 8
) (
    input  logic               iClock,
    input  logic               iReset,
    input  logic               iStart,
    input  logic [15:0]        iBlockSize,
    input  logic [3:0]         iPartOrder,
    input  logic [5:0]         iPredOrder,
    input  logic               iParamValid,
    input  logic [3:0]         iParam,
    output logic               oParamReady,
    input  logic               iSampleValid,
    input  logic signed [15:0] iSample,
    output logic               oSampleReady,
    input  logic               iEncValid,
    output logic               oValid,
    output logic signed [15:0] oSample,
    output logic [3:0]         oRiceParam,
    output logic               oChangeParam,
    output logic               oFlush,
    output logic               oWriterEnable,
    output logic               oBusy,
    output logic               oDone,
    output logic               oError
);

    typedef enum logic [3:0] {
        S_IDLE, S_CHECK, S_WAIT_PARAM, S_SET_PARAM, S_STREAM,
        S_DRAIN_PART, S_DRAIN_LAST, S_FLUSH, S_DONE
    } state_t;

    localparam logic [3:0] MAX_ORDER_C = 4'(MAX_ORDER);
    localparam logic [7:0] DRAIN_LOAD  = 8'(ENC_LATENCY);

    state_t             state_q, state_d;
    logic [15:0]        blocksize_q, blocksize_d;
    logic [3:0]         order_q, order_d;
    logic [5:0]         pred_q, pred_d;
    logic [8:0]         part_idx_q, part_idx_d;
    logic [15:0]        cnt_q, cnt_d;
    logic [7:0]         drain_q, drain_d;
    logic [3:0]         rice_param_q, rice_param_d;
    logic signed [15:0] sample_q, sample_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;

    logic [15:0] part_len;
    logic [15:0] order_mask;
    logic [8:0]  last_idx;
    logic        is_last;
    logic [15:0] load_cnt;
    logic        cfg_err;
    logic        sample_hs;

    always_comb begin
        part_len   = blocksize_q >> order_q;
        order_mask = ~(16'hFFFF << order_q);
        last_idx   = ~(9'h1FF << order_q);
        is_last    = (part_idx_q == last_idx);
        // Warm-up samples precede the residuals, so partition 0 is short by pred_order.
        load_cnt   = (part_idx_q == 9'd0) ? (part_len - {10'd0, pred_q}) : part_len;
        cfg_err    = (order_q > MAX_ORDER_C)
                   | (|(blocksize_q & order_mask))
                   | (blocksize_q == 16'd0)
                   | ({10'd0, pred_q} > part_len);
        sample_hs  = iSampleValid & (state_q == S_STREAM);
    end

    always_comb begin
        state_d      = state_q;
        blocksize_d  = blocksize_q;
        order_d      = order_q;
        pred_d       = pred_q;
        part_idx_d   = part_idx_q;
        cnt_d        = cnt_q;
        drain_d      = drain_q;
        rice_param_d = rice_param_q;
        sample_d     = sample_q;
        valid_d      = 1'b0;
        busy_d       = busy_q;
        error_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    blocksize_d = iBlockSize;
                    order_d     = iPartOrder;
                    pred_d      = iPredOrder;
                    state_d     = S_CHECK;
                end
            end
            S_CHECK: begin
                if (cfg_err) begin
                    error_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    part_idx_d = 9'd0;
                    busy_d     = 1'b1;
                    state_d    = S_WAIT_PARAM;
                end
            end
            S_WAIT_PARAM: begin
                if (iParamValid) begin
                    rice_param_d = iParam;
                    state_d      = S_SET_PARAM;
                end
            end
            S_SET_PARAM: begin
                cnt_d = load_cnt;
                if (load_cnt != 16'd0) begin
                    state_d = S_STREAM;
                end else if (is_last) begin
                    state_d = S_FLUSH;
                end else begin
                    // Nothing entered the encoder, so there is nothing to drain.
                    part_idx_d = part_idx_q + 9'd1;
                    state_d    = S_WAIT_PARAM;
                end
            end
            S_STREAM: begin
                if (sample_hs) begin
                    sample_d = iSample;
                    valid_d  = 1'b1;
                    cnt_d    = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        drain_d = DRAIN_LOAD;
                        state_d = is_last ? S_DRAIN_LAST : S_DRAIN_PART;
                    end
                end
            end
            S_DRAIN_PART, S_DRAIN_LAST: begin
                if (drain_q != 8'd0) begin
                    drain_d = drain_q - 8'd1;
                end else if (!iEncValid) begin
                    if (state_q == S_DRAIN_PART) begin
                        part_idx_d = part_idx_q + 9'd1;
                        state_d    = S_WAIT_PARAM;
                    end else begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iReset) begin
            state_q      <= S_IDLE;
            blocksize_q  <= '0;
            order_q      <= '0;
            pred_q       <= '0;
            part_idx_q   <= '0;
            cnt_q        <= '0;
            drain_q      <= '0;
            rice_param_q <= '0;
            sample_q     <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            blocksize_q  <= blocksize_d;
            order_q      <= order_d;
            pred_q       <= pred_d;
            part_idx_q   <= part_idx_d;
            cnt_q        <= cnt_d;
            drain_q      <= drain_d;
            rice_param_q <= rice_param_d;
            sample_q     <= sample_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        oParamReady   = (state_q == S_WAIT_PARAM);
        oSampleReady  = (state_q == S_STREAM);
        oChangeParam  = (state_q == S_SET_PARAM);
        oFlush        = (state_q == S_FLUSH);
        oWriterEnable = (state_q == S_SET_PARAM) || (state_q == S_FLUSH);
        oDone         = (state_q == S_DONE);
        oBusy         = busy_q;
        oError        = error_q;
        oValid        = valid_q;
        oSample       = sample_q;
        oRiceParam    = rice_param_q;
    end

endmodule

// File: tb/tb_rice_partition_sequencer.sv
// Scoreboard bench: drivers queue expected params/samples/partition counts,
// a negedge monitor checks every DUT event against them.
module tb_rice_partition_sequencer;

    logic               clk = 1'b0;
    logic               iReset = 1'b0;
    logic               iStart = 1'b0;
    logic [15:0]        iBlockSize = '0;
    logic [3:0]         iPartOrder = '0;
    logic [5:0]         iPredOrder = '0;
    logic               iParamValid = 1'b0;
    logic [3:0]         iParam = '0;
    logic               oParamReady;
    logic               iSampleValid = 1'b0;
    logic signed [15:0] iSample = '0;
    logic               oSampleReady;
    logic               iEncValid;
    logic               oValid;
    logic signed [15:0] oSample;
    logic [3:0]         oRiceParam;
    logic               oChangeParam, oFlush, oWriterEnable, oBusy, oDone, oError;

    always #5 clk = ~clk;

    rice_partition_sequencer #(.ENC_LATENCY(2), .MAX_ORDER(8)) dut (
        .iClock(clk), .iReset(iReset), .iStart(iStart), .iBlockSize(iBlockSize),
        .iPartOrder(iPartOrder), .iPredOrder(iPredOrder), .iParamValid(iParamValid),
        .iParam(iParam), .oParamReady(oParamReady), .iSampleValid(iSampleValid),
        .iSample(iSample), .oSampleReady(oSampleReady), .iEncValid(iEncValid),
        .oValid(oValid), .oSample(oSample), .oRiceParam(oRiceParam),
        .oChangeParam(oChangeParam), .oFlush(oFlush), .oWriterEnable(oWriterEnable),
        .oBusy(oBusy), .oDone(oDone), .oError(oError)
    );

    int checks = 0;
    int errors = 0;

    logic signed [15:0] exp_smp_q[$];
    logic [3:0]         exp_par_q[$];
    int                 exp_cnt_q[$];
    int seen_flush = 0, seen_done = 0, seen_error = 0, seen_pr = 0;
    int exp_flush = 0, exp_done = 0, exp_error = 0;

    // Encoder stand-in: oValid delayed by two cycles.
    logic enc_p1 = 1'b0, enc_p2 = 1'b0, hs_prev = 1'b0;
    logic done_prev = 1'b0, in_block = 1'b0;
    int   cur_cnt = 0;
    assign iEncValid = enc_p2;

    always @(posedge clk) begin
        enc_p1  <= oValid;
        enc_p2  <= enc_p1;
        hs_prev <= iSampleValid & oSampleReady & iReset;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [15:0] smp(input int blk, input int j);
        return 16'(j * 29 - 1000 + blk * 7);
    endfunction

    always @(negedge clk) begin
        if (oValid === 1'b1) begin
            if (exp_smp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid actual=%0d required=none", oSample);
            end else begin
                chk("sample", oSample, exp_smp_q.pop_front());
            end
            cur_cnt++;
        end
        if ((oValid | hs_prev) === 1'b1) chk("valid_latency", oValid, hs_prev);
        if (oChangeParam === 1'b1) begin
            if (exp_par_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_change_param actual=%0d required=none", oRiceParam);
            end else begin
                chk("rice_param", oRiceParam, exp_par_q.pop_front());
            end
            chk("valid_overlaps_change", oValid, 0);
            chk("enc_busy_at_change", iEncValid, 0);
            chk("writer_en_at_change", oWriterEnable, 1);
            if (in_block && exp_cnt_q.size() != 0) chk("part_count", cur_cnt, exp_cnt_q.pop_front());
            cur_cnt  = 0;
            in_block = 1'b1;
        end
        if (oFlush === 1'b1) begin
            seen_flush++;
            chk("writer_en_at_flush", oWriterEnable, 1);
            if (in_block && exp_cnt_q.size() != 0) chk("part_count_last", cur_cnt, exp_cnt_q.pop_front());
            in_block = 1'b0;
        end
        if (oDone === 1'b1) seen_done++;
        if (oError === 1'b1) seen_error++;
        if (oParamReady === 1'b1) seen_pr++;
        if (done_prev) chk("busy_after_done", oBusy, 0);
        done_prev = (oDone === 1'b1);
        if (iReset === 1'b0) begin
            in_block = 1'b0;
            cur_cnt  = 0;
        end
    end

    task automatic check_reset_outputs(input string name);
        chk(name, {oParamReady, oSampleReady, oValid, oSample, oRiceParam, oChangeParam,
                   oFlush, oWriterEnable, oBusy, oDone, oError}, 0);
    endtask

    task automatic run_block(input int blk, input int bs, input int ord, input int pred,
                             input int np, input int pa, input int pb, input int pc, input int pd,
                             input int ca, input int cb, input int cc, input int cd,
                             input bit gap, input int pdelay, input int abort_at, input bit exp_err);
        int  pars[4];
        int  cnts[4];
        int  nsmp, k, si, pwait, err_base, pr_base;
        bit  hs_p, hs_s, tog, fin, aborted;
        pars = '{pa, pb, pc, pd};
        cnts = '{ca, cb, cc, cd};
        err_base = seen_error;
        pr_base  = seen_pr;
        nsmp = bs - pred;
        if (exp_err) begin
            exp_error++;
        end else begin
            for (int j = 0; j < nsmp; j++) exp_smp_q.push_back(smp(blk, j));
            for (int i = 0; i < np; i++) begin
                exp_par_q.push_back(4'(pars[i]));
                exp_cnt_q.push_back(cnts[i]);
            end
            if (abort_at < 0) begin
                exp_flush++;
                exp_done++;
            end
        end

        iStart = 1'b1; iBlockSize = 16'(bs); iPartOrder = 4'(ord); iPredOrder = 6'(pred);
        @(posedge clk); #1;
        iStart = 1'b0;

        if (exp_err) begin
            @(posedge clk); #1;
            chk("error_pulse", oError, 1);
            chk("error_not_busy", oBusy, 0);
            @(posedge clk); #1;
            chk("error_one_cycle", oError, 0);
            repeat (3) @(posedge clk);
            #1;
            chk("error_count", seen_error - err_base, 1);
            chk("error_no_param_req", seen_pr - pr_base, 0);
            chk("error_flush_count", seen_flush, exp_flush);
            return;
        end

        k = 0; si = 0; pwait = 0; tog = 1'b1; fin = 1'b0; aborted = 1'b0;
        for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
            if (abort_at >= 0 && si == abort_at) begin
                iReset = 1'b0; iSampleValid = 1'b0; iParamValid = 1'b0;
                @(posedge clk); #1;
                check_reset_outputs("reset_mid_block");
                iReset = 1'b1;
                exp_smp_q.delete();
                exp_par_q.delete();
                exp_cnt_q.delete();
                aborted = 1'b1;
                fin = 1'b1;
            end else if (oDone === 1'b1) begin
                fin = 1'b1;
            end else begin
                iParamValid = 1'b0;
                if (oParamReady && k < np) begin
                    if (pwait >= pdelay) begin
                        iParamValid = 1'b1;
                        iParam = 4'(pars[k]);
                    end else begin
                        pwait++;
                    end
                end
                iSampleValid = gap ? tog : 1'b1;
                tog = ~tog;
                iSample = smp(blk, si);
                hs_p = iParamValid & oParamReady;
                hs_s = iSampleValid & oSampleReady;
                @(posedge clk); #1;
                if (hs_p) begin
                    k++;
                    pwait = 0;
                end
                if (hs_s) si++;
            end
        end
        iParamValid = 1'b0;
        iSampleValid = 1'b0;
        if (!fin) begin
            checks++; errors++;
            $display("FAIL block_timeout actual=running required=done blk=%0d", blk);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("flush_count", seen_flush, exp_flush);
        chk("done_count", seen_done, exp_done);
        chk("idle_not_busy", oBusy, 0);
        if (!aborted) begin
            chk("params_taken", k, np);
            chk("samples_taken", si, nsmp);
            chk("samples_left", exp_smp_q.size(), 0);
            chk("params_left", exp_par_q.size(), 0);
        end
    endtask

    initial begin
        iReset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        iReset = 1'b1;
        @(posedge clk); #1;

        // blk bs    ord pred np  params      counts          gap pdly abort err
        run_block(1, 4096, 0, 0, 1,  7, 0, 0, 0,  4096, 0, 0, 0,  0, 0, -1, 0);
        run_block(2, 16,   2, 2, 4,  3, 5, 0, 9,  2, 4, 4, 4,     0, 0, -1, 0);
        run_block(3, 8,    2, 2, 4,  1, 2, 3, 4,  0, 2, 2, 2,     0, 0, -1, 0);
        run_block(4, 16,   2, 4, 4,  8, 6, 4, 2,  0, 4, 4, 4,     0, 0, -1, 0);
        run_block(5, 100,  3, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,     0, 0, -1, 1);
        run_block(6, 512,  9, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,     0, 0, -1, 1);
        run_block(7, 16,   2, 5, 0,  0, 0, 0, 0,  0, 0, 0, 0,     0, 0, -1, 1);
        run_block(8, 0,    0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0,     0, 0, -1, 1);
        run_block(9, 16,   2, 2, 4,  15, 1, 6, 2, 2, 4, 4, 4,     1, 5, -1, 0);
        run_block(10, 16,  2, 2, 4,  3, 5, 0, 9,  2, 4, 4, 4,     0, 0, 4, 0);
        run_block(11, 16,  2, 2, 4,  3, 5, 0, 9,  2, 4, 4, 4,     0, 0, -1, 0);

        chk("total_errors_flagged", seen_error, exp_error);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
